// File: rtl/fifo_write_arbiter_pkg.sv
// Shared constants and state encoding for the FIFO write-side arbiter.
// The optional requester-0 priority mode is selected by FIFO_ARB_PRIO_EN in fifo_write_arbiter.sv.
package fifo_write_arbiter_pkg;

    localparam int DEFAULT_NUM_REQ    = 4;
    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_MAX_BURST  = 4;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_t;

endpackage

// File: rtl/fifo_write_arbiter_rr_picker.sv
// Combinational round-robin picker: first valid index after last_id, wrapping modulo NUM_REQ.
// Kept generic so a read-side scheduler can reuse it.
module rr_picker #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         valid,
    input  logic [$clog2(NUM_REQ)-1:0] last_id,
    output logic                       found,
    output logic [$clog2(NUM_REQ)-1:0] next_id
);

    localparam int IW = $clog2(NUM_REQ);

    // Scan from farthest to nearest offset so the nearest valid index is the last one written.
    always_comb begin
        int idx;
        found   = 1'b0;
        next_id = '0;
        idx     = 0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = int'(last_id) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (valid[IW'(idx)]) begin
                found   = 1'b1;
                next_id = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one FIFO write port between NUM_REQ producers.
// Define FIFO_ARB_PRIO_EN to give requester 0 absolute priority with unbounded bursts.
module fifo_write_arbiter
    import fifo_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = DEFAULT_NUM_REQ,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int MAX_BURST  = DEFAULT_MAX_BURST
) (
    input  logic                          FCLK,
    input  logic                          FRST,
    input  logic [NUM_REQ-1:0]            REQ_VALID,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
    output logic [NUM_REQ-1:0]            REQ_READY,
    input  logic                          FIFO_FULL,
    output logic                          FIFO_WR_EN,
    output logic [DATA_WIDTH-1:0]         FIFO_DATA_IN,
    output logic [$clog2(NUM_REQ)-1:0]    GRANT_ID,
    output logic                          BUSY,
    output logic                          state_dbg
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);

`ifdef FIFO_ARB_PRIO_EN
    localparam bit PRIO_EN = 1'b1;
`else
    localparam bit PRIO_EN = 1'b0;
`endif

    arb_state_t      state, state_nxt;
    logic [IW-1:0]   last_id, last_nxt;
    logic [IW-1:0]   grant_nxt;
    logic [BW-1:0]   beat_cnt, beat_nxt;
    logic            rr_found;
    logic [IW-1:0]   rr_id;
    logic [IW-1:0]   pick_id;
    logic            owner_valid;
    logic            owner_prio;

    rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .valid   (REQ_VALID),
        .last_id (last_id),
        .found   (rr_found),
        .next_id (rr_id)
    );

    // Requester 0 in priority mode: wins IDLE outright, never hits the burst cap, never moves last_id.
    always_comb begin
        pick_id = rr_id;
        if (PRIO_EN && REQ_VALID[0]) begin
            pick_id = '0;
        end
    end

    assign owner_prio  = PRIO_EN && (GRANT_ID == '0);
    assign owner_valid = REQ_VALID[GRANT_ID];
    assign BUSY        = (state == ARB_BURST);
    assign state_dbg   = state;

    always_comb begin
        state_nxt    = state;
        grant_nxt    = GRANT_ID;
        beat_nxt     = beat_cnt;
        last_nxt     = last_id;
        REQ_READY    = '0;
        FIFO_WR_EN   = 1'b0;
        FIFO_DATA_IN = '0;
        case (state)
            ARB_IDLE: begin
                if (rr_found) begin
                    grant_nxt = pick_id;
                    beat_nxt  = '0;
                    state_nxt = ARB_BURST;
                end
            end
            ARB_BURST: begin
                // Zero-latency write: the handshake cycle is the FIFO write cycle, so FULL is always current.
                REQ_READY[GRANT_ID] = !FIFO_FULL;
                FIFO_WR_EN          = owner_valid && !FIFO_FULL;
                FIFO_DATA_IN        = REQ_DATA[GRANT_ID*DATA_WIDTH +: DATA_WIDTH];
                if (!owner_valid) begin
                    state_nxt = ARB_IDLE;
                    if (!owner_prio) begin
                        last_nxt = GRANT_ID;
                    end
                end else if (!FIFO_FULL && !owner_prio) begin
                    beat_nxt = beat_cnt + 1'b1;
                    if (beat_cnt == BW'(MAX_BURST - 1)) begin
                        state_nxt = ARB_IDLE;
                        last_nxt  = GRANT_ID;
                    end
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge FCLK) begin
        if (FRST) begin
            state    <= ARB_IDLE;
            GRANT_ID <= '0;
            beat_cnt <= '0;
            last_id  <= IW'(NUM_REQ - 1);
        end else begin
            state    <= state_nxt;
            GRANT_ID <= grant_nxt;
            beat_cnt <= beat_nxt;
            last_id  <= last_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: per-cycle vector tables plus a write-order scoreboard.
// Priority-mode sequence runs only when FIFO_ARB_PRIO_EN is defined.
module tb_fifo_write_arbiter;

    typedef struct {
        logic       full;
        logic       rst;
        logic       exp_busy;
        logic       exp_wr;
        logic [1:0] exp_gid;
        logic [3:0] exp_rdy;
    } vec_t;

    logic        FCLK = 1'b0;
    logic        FRST;
    logic [3:0]  REQ_VALID;
    logic [31:0] REQ_DATA;
    logic [3:0]  REQ_READY;
    logic        FIFO_FULL;
    logic        FIFO_WR_EN;
    logic [7:0]  FIFO_DATA_IN;
    logic [1:0]  GRANT_ID;
    logic        BUSY;
    logic        state_dbg;

    logic [7:0]  src_q[4][$];
    logic [9:0]  exp_q[$];
    vec_t        tbl[$];
    string       scen;
    int          checks = 0;
    int          failures = 0;

    fifo_write_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
        .FCLK         (FCLK),
        .FRST         (FRST),
        .REQ_VALID    (REQ_VALID),
        .REQ_DATA     (REQ_DATA),
        .REQ_READY    (REQ_READY),
        .FIFO_FULL    (FIFO_FULL),
        .FIFO_WR_EN   (FIFO_WR_EN),
        .FIFO_DATA_IN (FIFO_DATA_IN),
        .GRANT_ID     (GRANT_ID),
        .BUSY         (BUSY),
        .state_dbg    (state_dbg)
    );

    always #5 FCLK = ~FCLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            if (src_q[i].size() > 0) begin
                REQ_VALID[i]       = 1'b1;
                REQ_DATA[i*8 +: 8] = src_q[i][0];
            end else begin
                REQ_VALID[i]       = 1'b0;
                REQ_DATA[i*8 +: 8] = 8'h00;
            end
        end
    endtask

    // One FCLK cycle: apply vector inputs, sample/check at negedge, retire handshakes after posedge.
    task automatic step(input bit do_chk, input vec_t v);
        logic [3:0] hs;
        logic [9:0] e;
        FIFO_FULL = v.full;
        FRST      = v.rst;
        @(negedge FCLK);
        if (do_chk) begin
            chk($sformatf("%s.busy", scen), BUSY, v.exp_busy);
            chk($sformatf("%s.wr_en", scen), FIFO_WR_EN, v.exp_wr);
            chk($sformatf("%s.grant_id", scen), GRANT_ID, v.exp_gid);
            chk($sformatf("%s.req_ready", scen), REQ_READY, v.exp_rdy);
            if (!v.exp_busy) chk($sformatf("%s.idle_data", scen), FIFO_DATA_IN, 0);
        end
        hs = REQ_VALID & REQ_READY;
        chk($sformatf("%s.wr_vs_handshake", scen), FIFO_WR_EN, |hs);
        chk($sformatf("%s.ready_onehot0", scen), $countones(REQ_READY) <= 1, 1);
        if (FIFO_WR_EN === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk($sformatf("%s.unexpected_write", scen), {GRANT_ID, FIFO_DATA_IN}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("%s.write_word", scen), {GRANT_ID, FIFO_DATA_IN}, e);
            end
        end
        @(posedge FCLK);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (hs[i]) void'(src_q[i].pop_front());
        end
        drive();
    endtask

    function automatic void add_vec(input logic f, input logic r, input logic b, input logic w,
                                    input logic [1:0] g, input logic [3:0] rd);
        vec_t v;
        v.full = f; v.rst = r; v.exp_busy = b; v.exp_wr = w; v.exp_gid = g; v.exp_rdy = rd;
        tbl.push_back(v);
    endfunction

    task automatic run_tbl();
        for (int i = 0; i < tbl.size(); i++) begin
            step(1'b1, tbl[i]);
        end
        tbl.delete();
    endtask

    task automatic reset_dut();
        vec_t v;
        v = '{full: 1'b0, rst: 1'b1, exp_busy: 1'b0, exp_wr: 1'b0, exp_gid: 2'd0, exp_rdy: 4'd0};
        step(1'b0, v);
        FRST = 1'b0;
    endtask

    task automatic load(input int id, input logic [7:0] d, input bit to_exp);
        src_q[id].push_back(d);
        if (to_exp) exp_q.push_back({id[1:0], d});
    endtask

    // Loads the 0,1,2,3,0 rotation workload with random data and its expected write order.
    task automatic load_rotation();
        logic [7:0] d;
        for (int k = 0; k < 4; k++) begin d = 8'($urandom_range(0, 255)); load(0, d, 1'b1); end
        for (int r = 1; r < 4; r++) begin
            for (int k = 0; k < 4; k++) begin d = 8'($urandom_range(0, 255)); load(r, d, 1'b1); end
        end
        for (int k = 0; k < 4; k++) begin d = 8'($urandom_range(0, 255)); load(0, d, 1'b1); end
        drive();
    endtask

    initial begin
        vec_t v;
        int   ids[5];
        int   budget;
        FRST      = 1'b1;
        FIFO_FULL = 1'b0;
        REQ_VALID = '0;
        REQ_DATA  = '0;

        scen = "reset";
        add_vec(0, 1, 0, 0, 2'd0, 4'b0000);
        add_vec(0, 0, 0, 0, 2'd0, 4'b0000);
        run_tbl();

        scen = "single";
        load(0, 8'hA1, 1'b1); load(0, 8'hB2, 1'b1); load(0, 8'hC3, 1'b1);
        drive();
        add_vec(0, 0, 0, 0, 2'd0, 4'b0000);
        add_vec(0, 0, 1, 1, 2'd0, 4'b0001);
        add_vec(0, 0, 1, 1, 2'd0, 4'b0001);
        add_vec(0, 0, 1, 1, 2'd0, 4'b0001);
        add_vec(0, 0, 1, 0, 2'd0, 4'b0001);
        add_vec(0, 0, 0, 0, 2'd0, 4'b0000);
        run_tbl();
        chk("single.drain", exp_q.size(), 0);

        scen = "rotate";
        reset_dut();
        load_rotation();
        ids = '{0, 1, 2, 3, 0};
        for (int b = 0; b < 5; b++) begin
            add_vec(0, 0, 0, 0, (b == 0) ? 2'd0 : 2'(ids[b-1]), 4'b0000);
            for (int k = 0; k < 4; k++) add_vec(0, 0, 1, 1, 2'(ids[b]), 4'b0001 << ids[b]);
        end
        add_vec(0, 0, 0, 0, 2'd0, 4'b0000);
        run_tbl();
        chk("rotate.drain", exp_q.size(), 0);

        scen = "full_stall";
        reset_dut();
        for (int k = 0; k < 4; k++) load(0, 8'(8'h30 + k), 1'b1);
        drive();
        add_vec(0, 0, 0, 0, 2'd0, 4'b0000);
        add_vec(0, 0, 1, 1, 2'd0, 4'b0001);
        add_vec(0, 0, 1, 1, 2'd0, 4'b0001);
        for (int k = 0; k < 5; k++) add_vec(1, 0, 1, 0, 2'd0, 4'b0000);
        add_vec(0, 0, 1, 1, 2'd0, 4'b0001);
        add_vec(0, 0, 1, 1, 2'd0, 4'b0001);
        add_vec(0, 0, 0, 0, 2'd0, 4'b0000);
        run_tbl();
        chk("full_stall.drain", exp_q.size(), 0);

        scen = "owner_drop";
        reset_dut();
        load(0, 8'h40, 1'b1); load(0, 8'h41, 1'b1);
        load(2, 8'h60, 1'b1); load(2, 8'h61, 1'b1);
        drive();
        add_vec(0, 0, 0, 0, 2'd0, 4'b0000);
        add_vec(0, 0, 1, 1, 2'd0, 4'b0001);
        add_vec(0, 0, 1, 1, 2'd0, 4'b0001);
        add_vec(0, 0, 1, 0, 2'd0, 4'b0001);
        add_vec(0, 0, 0, 0, 2'd0, 4'b0000);
        add_vec(0, 0, 1, 1, 2'd2, 4'b0100);
        add_vec(0, 0, 1, 1, 2'd2, 4'b0100);
        add_vec(0, 0, 1, 0, 2'd2, 4'b0100);
        add_vec(0, 0, 0, 0, 2'd2, 4'b0000);
        run_tbl();
        chk("owner_drop.drain", exp_q.size(), 0);

        // Reset lands on the third beat of requester 1; that beat is still written.
        scen = "reset_mid";
        reset_dut();
        for (int k = 0; k < 3; k++) load(1, 8'(8'h50 + k), 1'b1);
        src_q[1].push_back(8'h53);
        exp_q.push_back({2'd0, 8'h0F});
        exp_q.push_back({2'd1, 8'h53});
        drive();
        add_vec(0, 0, 0, 0, 2'd0, 4'b0000);
        add_vec(0, 0, 1, 1, 2'd1, 4'b0010);
        add_vec(0, 0, 1, 1, 2'd1, 4'b0010);
        run_tbl();
        load(0, 8'h0F, 1'b0);
        drive();
        add_vec(0, 1, 1, 1, 2'd1, 4'b0010);
        add_vec(0, 0, 0, 0, 2'd0, 4'b0000);
        add_vec(0, 0, 1, 1, 2'd0, 4'b0001);
        add_vec(0, 0, 1, 0, 2'd0, 4'b0001);
        add_vec(0, 0, 0, 0, 2'd0, 4'b0000);
        add_vec(0, 0, 1, 1, 2'd1, 4'b0010);
        add_vec(0, 0, 1, 0, 2'd1, 4'b0010);
        add_vec(0, 0, 0, 0, 2'd1, 4'b0000);
        run_tbl();
        chk("reset_mid.drain", exp_q.size(), 0);

`ifdef FIFO_ARB_PRIO_EN
        // last_id is 1 here, so plain round-robin would pick requester 3 first.
        scen = "prio";
        for (int k = 0; k < 6; k++) load(0, 8'(8'h70 + k), 1'b1);
        load(3, 8'h90, 1'b1); load(3, 8'h91, 1'b1);
        drive();
        add_vec(0, 0, 0, 0, 2'd1, 4'b0000);
        for (int k = 0; k < 6; k++) add_vec(0, 0, 1, 1, 2'd0, 4'b0001);
        add_vec(0, 0, 1, 0, 2'd0, 4'b0001);
        add_vec(0, 0, 0, 0, 2'd0, 4'b0000);
        add_vec(0, 0, 1, 1, 2'd3, 4'b1000);
        add_vec(0, 0, 1, 1, 2'd3, 4'b1000);
        add_vec(0, 0, 1, 0, 2'd3, 4'b1000);
        add_vec(0, 0, 0, 0, 2'd3, 4'b0000);
        run_tbl();
        chk("prio.drain", exp_q.size(), 0);
`endif

        // Random FULL pressure never changes write order, only timing.
        scen = "random_full";
        reset_dut();
        load_rotation();
        budget = 0;
        while ((exp_q.size() != 0 || BUSY !== 1'b0) && budget < 400) begin
            v = '{full: ($urandom_range(0, 3) == 0), rst: 1'b0, exp_busy: 1'b0, exp_wr: 1'b0,
                  exp_gid: 2'd0, exp_rdy: 4'd0};
            step(1'b0, v);
            budget++;
        end
        FIFO_FULL = 1'b0;
        chk("random_full.timeout", budget < 400, 1);
        chk("random_full.drain", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
